// File: rtl/mem_pkg.sv
// Shared definitions for the CPU-side block RAM initiator: size codes, FSM states,
// data width and the byte-lane mask helper.
package mem_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_RMW_WR,
    ST_RESP
  } state_t;

  // Lanes touched by an access; an illegal size touches nothing.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      SZ_BYTE: m = 4'b0001 << lo;
      SZ_HALF: m = 4'b0011 << lo;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_port_master_if.sv
// Request/response handshake plus RAM port bundle between the CPU datapath,
// mem_port_master and the synchronous block RAM.
interface mem_port_master_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [DATA_W-1:0] resp_rdata;
  logic              ram_wea;
  logic [ADDR_W-1:0] ram_addra;
  logic [DATA_W-1:0] ram_dina;
  logic [DATA_W-1:0] ram_douta;

  modport master (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, ram_douta,
    output req_ready, resp_valid, resp_err, resp_rdata, ram_wea, ram_addra, ram_dina
  );

  modport slave (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, ram_douta,
    input  req_ready, resp_valid, resp_err, resp_rdata, ram_wea, ram_addra, ram_dina
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte mask, store merge into a read word, and load
// extraction with sign/zero extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        lo,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [3:0]        mask,
  output logic [DATA_W-1:0] merged,
  output logic [DATA_W-1:0] load_data
);
  logic [4:0]        shamt;
  logic [DATA_W-1:0] wshift;
  logic [DATA_W-1:0] rshift;

  assign shamt  = {lo, 3'b000};
  assign wshift = wdata << shamt;
  assign rshift = rdata >> shamt;
  assign mask   = lane_mask(size, lo);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merged[8*gi +: 8] = mask[gi] ? wshift[8*gi +: 8] : rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    load_data = rshift;
    case (size)
      SZ_BYTE: load_data = {{24{is_signed & rshift[7]}}, rshift[7:0]};
      SZ_HALF: load_data = {{16{is_signed & rshift[15]}}, rshift[15:0]};
      default: load_data = rshift;
    endcase
  end
endmodule

// File: rtl/mem_port_master.sv
// Load/store initiator for the 32-bit block RAM: alignment checks, lane steering
// and read-modify-write for sub-word stores.
module mem_port_master
  import mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clka,
  input  logic              rst_n,
  mem_port_master_if.master bus
);
  state_t            state_reg, state_next;
  logic              we_reg;
  logic              signed_reg;
  logic [1:0]        size_reg;
  logic [1:0]        lo_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [ADDR_W-1:0] addra_reg;
  logic [DATA_W-1:0] dina_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              err_reg;

  logic              accept;
  logic              misaligned;
  logic              out_of_range;
  logic              req_err;
  logic [3:0]        mask;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] load_data;

  assign accept       = bus.req_valid && (state_reg == ST_IDLE);
  assign out_of_range = (bus.req_addr >> (ADDR_W + 2)) != '0;
  assign req_err      = (bus.req_size == SZ_BAD) || misaligned || out_of_range;

  always_comb begin
    misaligned = 1'b0;
    case (bus.req_size)
      SZ_HALF: misaligned = bus.req_addr[0];
      SZ_WORD: misaligned = |bus.req_addr[1:0];
      default: misaligned = 1'b0;
    endcase
  end

  mem_lane_align u_align (
    .size      (size_reg),
    .lo        (lo_reg),
    .is_signed (signed_reg),
    .wdata     (wdata_reg),
    .rdata     (bus.ram_douta),
    .mask      (mask),
    .merged    (merged),
    .load_data (load_data)
  );

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Full-word stores need no read, so they reuse the write state directly.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (req_err)
            state_next = ST_RESP;
          else if (bus.req_we && (bus.req_size == SZ_WORD))
            state_next = ST_RMW_WR;
          else
            state_next = ST_RD;
        end
      end
      ST_RD:     state_next = ST_CAP;
      ST_CAP:    state_next = we_reg ? ST_RMW_WR : ST_RESP;
      ST_RMW_WR: state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      we_reg     <= 1'b0;
      signed_reg <= 1'b0;
      size_reg   <= SZ_BYTE;
      lo_reg     <= 2'b00;
      wdata_reg  <= '0;
      addra_reg  <= '0;
      dina_reg   <= '0;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
    end else if (accept) begin
      we_reg     <= bus.req_we;
      signed_reg <= bus.req_signed;
      size_reg   <= bus.req_size;
      lo_reg     <= bus.req_addr[1:0];
      wdata_reg  <= bus.req_wdata;
      addra_reg  <= bus.req_addr[ADDR_W+1:2];
      err_reg    <= req_err;
      rdata_reg  <= '0;
      if (bus.req_we)
        dina_reg <= bus.req_wdata;
    end else if (state_reg == ST_CAP) begin
      if (we_reg)
        dina_reg <= merged;
      else
        rdata_reg <= load_data;
    end
  end

  assign bus.req_ready  = (state_reg == ST_IDLE);
  assign bus.resp_valid = (state_reg == ST_RESP);
  assign bus.resp_err   = (state_reg == ST_RESP) && err_reg;
  assign bus.resp_rdata = rdata_reg;
  assign bus.ram_wea    = (state_reg == ST_RMW_WR);
  assign bus.ram_addra  = addra_reg;
  assign bus.ram_dina   = dina_reg;
endmodule
